// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: single-port word memory behind a req/gnt/rvalid data bus.
// Fixed-latency access with programmable wait states between grant and access.
module data_mem_ctrl #(
   parameter int WAIT_STATES = 1,
   parameter int DEPTH_WORDS = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        data_req_i,
   output logic        data_gnt_o,
   input  logic [31:0] data_addr_i,
   input  logic        data_wr_i,
   input  logic [3:0]  data_be_i,
   input  logic [31:0] data_wdata_i,
   output logic        data_rvalid_o,
   output logic [31:0] data_rdata_o
);

   localparam int AW = $clog2(DEPTH_WORDS);
   localparam logic [3:0] CNT_INIT =
      (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESP
   } state_t;

   state_t        state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic [AW-1:0] idx_q, idx_d;
   logic          wr_q, wr_d;
   logic [3:0]    be_q, be_d;
   logic [31:0]   wdata_q, wdata_d;
   logic          rvalid_q, rvalid_d;
   logic [31:0]   rdata_q, rdata_d;

   logic          acc_en;
   logic [AW-1:0] acc_idx;
   logic          acc_wr;
   logic [3:0]    acc_be;
   logic [31:0]   acc_wdata;

   logic [31:0]   mem [DEPTH_WORDS];

   // Byte offset and bits above the array size never select a word.
   logic unused_addr;
   assign unused_addr = ^{data_addr_i[31:AW+2], data_addr_i[1:0]};

   // Next-state, capture and access decode; with zero wait states the
   // access uses the live inputs since the capture flops load on that edge.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      idx_d      = idx_q;
      wr_d       = wr_q;
      be_d       = be_q;
      wdata_d    = wdata_q;
      data_gnt_o = 1'b0;
      acc_en     = 1'b0;
      acc_idx    = idx_q;
      acc_wr     = wr_q;
      acc_be     = be_q;
      acc_wdata  = wdata_q;
      unique case (state_q)
         S_IDLE: begin
            data_gnt_o = data_req_i;
            if (data_req_i) begin
               idx_d   = data_addr_i[AW+1:2];
               wr_d    = data_wr_i;
               be_d    = data_be_i;
               wdata_d = data_wdata_i;
               if (WAIT_STATES > 0) begin
                  state_d = S_WAIT;
                  cnt_d   = CNT_INIT;
               end else begin
                  state_d   = S_RESP;
                  acc_en    = 1'b1;
                  acc_idx   = data_addr_i[AW+1:2];
                  acc_wr    = data_wr_i;
                  acc_be    = data_be_i;
                  acc_wdata = data_wdata_i;
               end
            end
         end
         S_WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d = S_RESP;
               acc_en  = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_RESP: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (rst) begin
         data_gnt_o = 1'b0;
         acc_en     = 1'b0;
      end
      rvalid_d = acc_en;
      rdata_d  = (acc_en && !acc_wr) ? mem[acc_idx] : 32'd0;
   end

   // Control and response registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= 4'd0;
         rvalid_q <= 1'b0;
         rdata_q  <= 32'd0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rvalid_q <= rvalid_d;
         rdata_q  <= rdata_d;
      end
   end

   // Transaction capture; contents are only meaningful after a grant.
   always_ff @(posedge clk) begin
      idx_q   <= idx_d;
      wr_q    <= wr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
   end

   // Byte-lane writes; array contents survive reset.
   always_ff @(posedge clk) begin
      if (acc_en && acc_wr) begin
         for (int b = 0; b < 4; b++) begin
            if (acc_be[b]) begin
               mem[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
            end
         end
      end
   end

   assign data_rvalid_o = rvalid_q;
   assign data_rdata_o  = rdata_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: directed scoreboard bench for data_mem_ctrl.
// Main instance uses one wait state, a second instance uses none.
module tb_data_mem_ctrl;

   localparam int WS = 1;

   logic        clk = 1'b0;
   logic        rst;
   logic        req, gnt, wr, rvalid;
   logic [31:0] addr, wdata, rdata;
   logic [3:0]  be;
   logic        z_req, z_gnt, z_wr, z_rvalid;
   logic [31:0] z_addr, z_wdata, z_rdata;
   logic [3:0]  z_be;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   typedef struct {
      logic [31:0] data;
      int          cyc;
   } exp_t;

   exp_t sb[$];
   exp_t e_m;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   data_mem_ctrl #(.WAIT_STATES(WS), .DEPTH_WORDS(1024)) dut (
      .clk(clk), .rst(rst),
      .data_req_i(req), .data_gnt_o(gnt),
      .data_addr_i(addr), .data_wr_i(wr),
      .data_be_i(be), .data_wdata_i(wdata),
      .data_rvalid_o(rvalid), .data_rdata_o(rdata)
   );

   data_mem_ctrl #(.WAIT_STATES(0), .DEPTH_WORDS(1024)) dut0 (
      .clk(clk), .rst(rst),
      .data_req_i(z_req), .data_gnt_o(z_gnt),
      .data_addr_i(z_addr), .data_wr_i(z_wr),
      .data_be_i(z_be), .data_wdata_i(z_wdata),
      .data_rvalid_o(z_rvalid), .data_rdata_o(z_rdata)
   );

   // Response monitor: pops the scoreboard on every rvalid.
   always @(negedge clk) begin
      if (rvalid === 1'b1) begin
         checks++;
         assert (gnt === 1'b0) else begin
            errors++;
            $error("FAIL gnt_in_resp got=%b exp=0", gnt);
         end
         checks++;
         assert (sb.size() > 0) else begin
            errors++;
            $error("FAIL spurious_rvalid cyc=%0d got=1 exp=0", cyc);
         end
         if (sb.size() > 0) begin
            e_m = sb.pop_front();
            checks++;
            assert (rdata === e_m.data) else begin
               errors++;
               $error("FAIL rdata got=%h exp=%h", rdata, e_m.data);
            end
            checks++;
            assert (cyc === e_m.cyc) else begin
               errors++;
               $error("FAIL rvalid_cyc got=%0d exp=%0d", cyc, e_m.cyc);
            end
         end
      end else begin
         checks++;
         assert (rdata === 32'd0) else begin
            errors++;
            $error("FAIL rdata_idle got=%h exp=0", rdata);
         end
      end
   end

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      checks++;
      assert (sb.size() == 0) else begin
         errors++;
         $error("FAIL rvalid_timeout got=%0d pending exp=0", sb.size());
      end
      sb.delete();
   endtask

   task automatic wait_gnt(output int gc);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (gnt !== 1'b1 && n < 20);
      gc = cyc;
      checks++;
      assert (gnt === 1'b1) else begin
         errors++;
         $error("FAIL gnt_timeout got=%b exp=1", gnt);
      end
   endtask

   // One transaction on the main instance; inputs are scrambled after grant.
   task automatic xact(input logic w, input logic [31:0] a,
                       input logic [3:0] b, input logic [31:0] d,
                       input logic [31:0] exp);
      int gc;
      @(posedge clk); #1;
      req = 1'b1; wr = w; addr = a; be = b; wdata = d;
      wait_gnt(gc);
      if (gnt === 1'b1) sb.push_back('{exp, gc + WS + 1});
      @(posedge clk); #1;
      req = 1'b0; wr = ~w; addr = 32'hFFC; be = ~b; wdata = ~d;
      drain();
   endtask

   // One transaction on the zero-wait instance.
   task automatic z_xact(input logic w, input logic [31:0] a,
                         input logic [3:0] b, input logic [31:0] d,
                         input logic [31:0] exp);
      @(posedge clk); #1;
      z_req = 1'b1; z_wr = w; z_addr = a; z_be = b; z_wdata = d;
      @(negedge clk);
      checks++;
      assert (z_gnt === 1'b1) else begin
         errors++;
         $error("FAIL z_gnt got=%b exp=1", z_gnt);
      end
      @(posedge clk); #1;
      z_req = 1'b0; z_addr = 32'h0; z_wdata = ~d;
      @(negedge clk);
      checks++;
      assert (z_rvalid === 1'b1) else begin
         errors++;
         $error("FAIL z_rvalid got=%b exp=1", z_rvalid);
      end
      checks++;
      assert (z_rdata === exp) else begin
         errors++;
         $error("FAIL z_rdata got=%h exp=%h", z_rdata, exp);
      end
      @(negedge clk);
      checks++;
      assert (z_rvalid === 1'b0) else begin
         errors++;
         $error("FAIL z_rvalid_pulse got=%b exp=0", z_rvalid);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int g[3];
      int ng;
      int n;
      int gc;
      rst = 1'b1;
      req = 1'b1; wr = 1'b0; addr = 32'h0; be = 4'h0; wdata = 32'h0;
      z_req = 1'b0; z_wr = 1'b0; z_addr = 32'h0; z_be = 4'h0;
      z_wdata = 32'h0;
      repeat (2) @(negedge clk);
      checks++;
      assert (gnt === 1'b0) else begin
         errors++;
         $error("FAIL gnt_in_reset got=%b exp=0", gnt);
      end
      checks++;
      assert (rvalid === 1'b0) else begin
         errors++;
         $error("FAIL rvalid_reset got=%b exp=0", rvalid);
      end
      @(posedge clk); #1;
      rst = 1'b0; req = 1'b0;

      xact(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 32'h0);
      xact(1'b0, 32'h10, 4'hF, 32'h0, 32'hDEADBEEF);
      xact(1'b0, 32'h13, 4'h0, 32'h0, 32'hDEADBEEF);

      xact(1'b1, 32'h20, 4'hF, 32'h11223344, 32'h0);
      xact(1'b1, 32'h20, 4'b0101, 32'hAABBCCDD, 32'h0);
      xact(1'b0, 32'h20, 4'hF, 32'h0, 32'h11BB33DD);
      xact(1'b1, 32'h20, 4'h0, 32'hFFFFFFFF, 32'h0);
      xact(1'b0, 32'h20, 4'hF, 32'h0, 32'h11BB33DD);

      xact(1'b1, 32'h1000, 4'hF, 32'hCAFEF00D, 32'h0);
      xact(1'b0, 32'h0000, 4'hF, 32'h0, 32'hCAFEF00D);

      @(posedge clk); #1;
      req = 1'b1; wr = 1'b0; addr = 32'h10; be = 4'hF;
      ng = 0;
      n = 0;
      while (ng < 3 && n < 30) begin
         @(negedge clk);
         n++;
         if (gnt === 1'b1) begin
            g[ng] = cyc;
            ng++;
            sb.push_back('{32'hDEADBEEF, cyc + WS + 1});
         end
      end
      @(posedge clk); #1;
      req = 1'b0;
      checks++;
      assert (ng === 3) else begin
         errors++;
         $error("FAIL b2b_grants got=%0d exp=3", ng);
      end
      if (ng == 3) begin
         checks++;
         assert (g[1] - g[0] === 3) else begin
            errors++;
            $error("FAIL b2b_gap1 got=%0d exp=3", g[1] - g[0]);
         end
         checks++;
         assert (g[2] - g[0] === 6) else begin
            errors++;
            $error("FAIL b2b_gap2 got=%0d exp=6", g[2] - g[0]);
         end
      end
      drain();

      xact(1'b1, 32'h40, 4'hF, 32'h0, 32'h0);
      @(posedge clk); #1;
      req = 1'b1; wr = 1'b1; addr = 32'h40; be = 4'hF;
      wdata = 32'h12345678;
      wait_gnt(gc);
      @(posedge clk); #1;
      rst = 1'b1; req = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (4) @(negedge clk);
      xact(1'b0, 32'h40, 4'hF, 32'h0, 32'h0);

      z_xact(1'b1, 32'h8, 4'hF, 32'h55AA00FF, 32'h0);
      z_xact(1'b0, 32'h8, 4'hF, 32'h0, 32'h55AA00FF);
      z_xact(1'b1, 32'h8, 4'b1000, 32'h99000000, 32'h0);
      z_xact(1'b0, 32'h8, 4'hF, 32'h0, 32'h99AA00FF);

      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
